// File: rtl/pp_limb_dispatch_if.sv
// Operand-pair intake and limb-job output bundle of the radix-54 partial-product dispatcher.
// Handshake rule on both channels: a transfer happens on a rising clk edge where valid & ready; while valid & ~ready the source holds valid and its payload stable.
interface pp_limb_dispatch_if #(
  parameter int RADIX   = 54,
  parameter int SHIFT_W = 7,
  parameter int TAG_W   = 4
);
  localparam int LW = RADIX / 2;

  logic               in_valid;
  logic               in_ready;
  logic [RADIX-1:0]   in_a;
  logic [RADIX-1:0]   in_b;
  logic [TAG_W-1:0]   in_tag;

  logic               out_valid;
  logic               out_ready;
  logic [LW-1:0]      out_a;
  logic [LW-1:0]      out_b;
  logic [SHIFT_W-1:0] out_shift;
  logic [1:0]         out_idx;
  logic               out_last;
  logic [TAG_W-1:0]   out_tag;

  // Dispatcher side: consumes operand pairs, produces limb jobs.
  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_a, out_b, out_shift, out_idx, out_last, out_tag
  );

  // Environment side: offers operand pairs, consumes limb jobs.
  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_shift, out_idx, out_last, out_tag
  );
endinterface

// File: rtl/pp_limb_dispatch.sv
// Splits one RADIX-bit operand pair into lo/hi limbs and streams the four limb-pair
// multiply jobs (with product shift) to the downstream limb multiplier.
module pp_limb_dispatch #(
  parameter int RADIX   = 54,
  parameter int SHIFT_W = 7,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pp_limb_dispatch_if.slave bus,
  output logic              busy,
  output logic              dbg_state_o
);
  localparam int LW = RADIX / 2;
  localparam logic [SHIFT_W-1:0] SH_ONE = SHIFT_W'(LW);
  localparam logic [SHIFT_W-1:0] SH_TWO = SHIFT_W'(2 * LW);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  state_e             state_q;
  logic [RADIX-1:0]   a_q, b_q;
  logic               out_valid_q;
  logic [LW-1:0]      out_a_q, out_b_q;
  logic [SHIFT_W-1:0] out_shift_q;
  logic [1:0]         out_idx_q;
  logic               out_last_q;
  logic [TAG_W-1:0]   out_tag_q;

  logic               job_acc, last_acc, in_ready, accept;
  logic [1:0]         idx_d;
  logic [LW-1:0]      job_a_d, job_b_d;
  logic [SHIFT_W-1:0] job_shift_d;

  assign job_acc  = out_valid_q & bus.out_ready;
  assign last_acc = job_acc & (out_idx_q == 2'd3);
  assign in_ready = (state_q == IDLE) | ((state_q == ISSUE) & last_acc);
  assign accept   = bus.in_valid & in_ready;

  // Job idx bit 1 picks the A limb, bit 0 picks the B limb; shift is LW per high limb.
  always_comb begin
    idx_d   = out_idx_q + 2'd1;
    job_a_d = idx_d[1] ? a_q[RADIX-1:LW] : a_q[LW-1:0];
    job_b_d = idx_d[0] ? b_q[RADIX-1:LW] : b_q[LW-1:0];
    case (idx_d)
      2'd0:    job_shift_d = '0;
      2'd3:    job_shift_d = SH_TWO;
      default: job_shift_d = SH_ONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_shift_q <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_tag_q   <= '0;
    end else if (accept) begin
      // Covers both a fresh start and the zero-bubble hand-over on the last-job cycle.
      state_q     <= ISSUE;
      a_q         <= bus.in_a;
      b_q         <= bus.in_b;
      out_valid_q <= 1'b1;
      out_a_q     <= bus.in_a[LW-1:0];
      out_b_q     <= bus.in_b[LW-1:0];
      out_shift_q <= '0;
      out_idx_q   <= 2'd0;
      out_last_q  <= 1'b0;
      out_tag_q   <= bus.in_tag;
    end else if (last_acc) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_shift_q <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_tag_q   <= '0;
    end else if (job_acc) begin
      out_a_q     <= job_a_d;
      out_b_q     <= job_b_d;
      out_shift_q <= job_shift_d;
      out_idx_q   <= idx_d;
      out_last_q  <= (idx_d == 2'd3);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_shift = out_shift_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_tag   = out_tag_q;
  assign busy          = (state_q == ISSUE);
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_pp_limb_dispatch.sv
// Directed and randomized bench for pp_limb_dispatch; random jobs are checked by
// recombining the limb products per operation and comparing with A*B.
module tb_pp_limb_dispatch;
  localparam int RADIX   = 54;
  localparam int SHIFT_W = 7;
  localparam int TAG_W   = 4;
  localparam int LW      = RADIX / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic dbg_state;

  int n_asserts = 0;
  int n_fails   = 0;

  pp_limb_dispatch_if #(.RADIX(RADIX), .SHIFT_W(SHIFT_W), .TAG_W(TAG_W)) bus ();

  pp_limb_dispatch #(.RADIX(RADIX), .SHIFT_W(SHIFT_W), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic chk_beat(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] sh, input logic [31:0] idx,
                          input logic [31:0] last, input logic [31:0] tag);
    chk({nm, "_valid"}, 128'(bus.out_valid), 128'(1));
    chk({nm, "_a"},     128'(bus.out_a),     128'(a));
    chk({nm, "_b"},     128'(bus.out_b),     128'(b));
    chk({nm, "_shift"}, 128'(bus.out_shift), 128'(sh));
    chk({nm, "_idx"},   128'(bus.out_idx),   128'(idx));
    chk({nm, "_last"},  128'(bus.out_last),  128'(last));
    chk({nm, "_tag"},   128'(bus.out_tag),   128'(tag));
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, 128'(bus.out_valid), 128'(0));
    chk({nm, "_ready"}, 128'(bus.in_ready),  128'(1));
    chk({nm, "_busy"},  128'(busy),          128'(0));
  endtask

  task automatic offer(input logic [RADIX-1:0] a, input logic [RADIX-1:0] b,
                       input logic [TAG_W-1:0] tag);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
  endtask

  // ---------------- scoreboard (random phase) ----------------
  logic [2*RADIX-1:0] exp_q[$];
  logic [TAG_W-1:0]   tag_q[$];
  bit                 rnd_on = 1'b0;
  int                 beat_cnt = 0;
  logic [2*RADIX-1:0] acc = '0;
  bit                 stall_prev = 1'b0;
  logic [68:0]        held;

  function automatic logic [68:0] payload();
    return {bus.out_valid, bus.out_a, bus.out_b, bus.out_shift, bus.out_idx,
            bus.out_last, bus.out_tag};
  endfunction

  always @(negedge clk) begin
    if (rnd_on && rst_n) begin
      if (stall_prev) chk("stall_hold", 128'(payload()), 128'(held));
      stall_prev = 1'b0;
      if (bus.out_valid && !bus.out_ready) begin
        stall_prev = 1'b1;
        held       = payload();
      end else if (bus.out_valid && bus.out_ready) begin
        logic [2*RADIX-1:0] pa, pb;
        chk("rnd_idx", 128'(bus.out_idx), 128'(beat_cnt));
        chk("rnd_last", 128'(bus.out_last), 128'(beat_cnt == 3));
        chk("rnd_pending", 128'(tag_q.size() > 0), 128'(1));
        if (tag_q.size() > 0) chk("rnd_tag", 128'(bus.out_tag), 128'(tag_q[0]));
        pa  = (2*RADIX)'(bus.out_a);
        pb  = (2*RADIX)'(bus.out_b);
        acc = acc + ((pa * pb) << bus.out_shift);
        if (beat_cnt == 3) begin
          if (exp_q.size() > 0) begin
            chk("rnd_sum", 128'(acc), 128'(exp_q[0]));
            void'(exp_q.pop_front());
            void'(tag_q.pop_front());
          end
          beat_cnt = 0;
          acc      = '0;
        end else begin
          beat_cnt++;
        end
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [RADIX-1:0] ra, rb;
    logic [TAG_W-1:0] rt;
    bit got;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    // 1. reset state
    repeat (3) step();
    chk_idle("rst");
    chk("rst_a",     128'(bus.out_a),     128'(0));
    chk("rst_b",     128'(bus.out_b),     128'(0));
    chk("rst_shift", 128'(bus.out_shift), 128'(0));
    chk("rst_idx",   128'(bus.out_idx),   128'(0));
    chk("rst_last",  128'(bus.out_last),  128'(0));
    chk("rst_tag",   128'(bus.out_tag),   128'(0));
    chk("rst_state", 128'(dbg_state),     128'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_valid", 128'(bus.out_valid), 128'(0));
    end

    // 2. single operation, out_ready held high
    bus.out_ready = 1'b1;
    offer({27'd5, 27'd3}, {27'd7, 27'd2}, 4'hA);
    step();
    bus.in_valid = 1'b0;
    bus.in_a     = '1;
    bus.in_b     = '1;
    chk_beat("single0", 3, 2, 0, 0, 0, 4'hA);
    chk("single0_busy", 128'(busy), 128'(1));
    step(); chk_beat("single1", 3, 7, LW, 1, 0, 4'hA);
    step(); chk_beat("single2", 5, 2, LW, 2, 0, 4'hA);
    step(); chk_beat("single3", 5, 7, 2*LW, 3, 1, 4'hA);
    step(); chk_idle("single_end");

    // 3. backpressure during idx1
    offer({27'd5, 27'd3}, {27'd7, 27'd2}, 4'h3);
    step();
    bus.in_valid = 1'b0;
    chk_beat("bp0", 3, 2, 0, 0, 0, 4'h3);
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_beat("bp_hold", 3, 7, LW, 1, 0, 4'h3);
      chk("bp_busy", 128'(busy), 128'(1));
      step();
    end
    chk_beat("bp_hold_end", 3, 7, LW, 1, 0, 4'h3);
    bus.out_ready = 1'b1;
    step(); chk_beat("bp2", 5, 2, LW, 2, 0, 4'h3);
    step(); chk_beat("bp3", 5, 7, 2*LW, 3, 1, 4'h3);
    step(); chk_idle("bp_end");

    // 4. back-to-back: op B waits and is taken on op A's last-job cycle
    offer({27'd5, 27'd3}, {27'd7, 27'd2}, 4'hA);
    step();
    offer({27'd9, 27'd11}, {27'd13, 27'd6}, 4'hB);
    chk("b2b_ready_idx0", 128'(bus.in_ready), 128'(0));
    step(); chk("b2b_ready_idx1", 128'(bus.in_ready), 128'(0));
    step(); chk("b2b_ready_idx2", 128'(bus.in_ready), 128'(0));
    step();
    chk_beat("b2b_a3", 5, 7, 2*LW, 3, 1, 4'hA);
    chk("b2b_ready_idx3", 128'(bus.in_ready), 128'(1));
    step();
    bus.in_valid = 1'b0;
    chk_beat("b2b_b0", 11, 6, 0, 0, 0, 4'hB);
    step(); chk_beat("b2b_b1", 11, 13, LW, 1, 0, 4'hB);
    step(); chk_beat("b2b_b2", 9, 6, LW, 2, 0, 4'hB);
    step(); chk_beat("b2b_b3", 9, 13, 2*LW, 3, 1, 4'hB);
    step(); chk_idle("b2b_end");

    // 5. reset in the middle of an operation
    offer({27'd5, 27'd3}, {27'd7, 27'd2}, 4'h7);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    chk_beat("mid_pre", 5, 2, LW, 2, 0, 4'h7);
    rst_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_idx", 128'(bus.out_idx), 128'(0));
    chk("mid_rst_tag", 128'(bus.out_tag), 128'(0));
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_idle("mid_after");
    end

    // 6. random operations with random stalls
    rnd_on = 1'b1;
    for (int op = 0; op < 1000; op++) begin
      ra = RADIX'({$urandom(), $urandom()});
      rb = RADIX'({$urandom(), $urandom()});
      rt = TAG_W'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        bus.in_valid = 1'b0;
        step();
      end
      offer(ra, rb, rt);
      got = 1'b0;
      for (int c = 0; c < 64 && !got; c++) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (bus.in_ready) begin
          got = 1'b1;
          exp_q.push_back((2*RADIX)'(ra) * (2*RADIX)'(rb));
          tag_q.push_back(rt);
        end
        step();
      end
      chk("rnd_accept_wait", 128'(got), 128'(1));
      bus.in_valid = 1'b0;
    end
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.out_ready = 1'b1;
    repeat (2) step();
    chk("rnd_drain", 128'(exp_q.size()), 128'(0));
    chk("rnd_end_busy", 128'(busy), 128'(0));
    rnd_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
